// File: rtl/parking_gate_controller.sv
// Parking gate controller with two pools: reserved (uni) and public.
// Handles the entry and exit lane request handshakes, the per-lane gate-open
// timers, the time-of-day public capacity ramp, and a saturating deny counter.
module parking_gate_controller #(
    parameter int UNI_CAP    = 500,
    parameter int PUB_BASE   = 200,
    parameter int PUB_MAX    = 500,
    parameter int RAMP_START = 13,
    parameter int RAMP_STEP  = 50,
    parameter int CNT_W      = 10,
    parameter int GATE_HOLD  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       hour,
    input  logic             entry_req,
    input  logic             entry_uni,
    input  logic             exit_req,
    input  logic             exit_uni,
    output logic             entry_grant,
    output logic             entry_deny,
    output logic             exit_grant,
    output logic             exit_deny,
    output logic             entry_gate_open,
    output logic             exit_gate_open,
    output logic [CNT_W-1:0] uni_parked,
    output logic [CNT_W-1:0] pub_parked,
    output logic [CNT_W-1:0] pub_cap,
    output logic [CNT_W-1:0] uni_free,
    output logic [CNT_W-1:0] pub_free,
    output logic             uni_full,
    output logic             pub_full,
    output logic [15:0]      deny_count
);

    // The capacity ramp is computed with four bits of headroom so that
    // intermediate sums cannot wrap before the ceiling clamp is applied.
    localparam int CW    = CNT_W + 4;
    localparam int TMR_W = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;

    localparam logic [CNT_W-1:0] UNI_CAP_C    = CNT_W'(UNI_CAP);
    localparam logic [CW-1:0]    PUB_BASE_W   = CW'(PUB_BASE);
    localparam logic [CW-1:0]    PUB_MAX_W    = CW'(PUB_MAX);
    localparam logic [CW-1:0]    RAMP_START_W = CW'(RAMP_START);
    localparam logic [CW-1:0]    RAMP_STEP_W  = CW'(RAMP_STEP);
    localparam logic [TMR_W-1:0] HOLD_INIT    = TMR_W'(GATE_HOLD - 1);

    typedef enum logic {
        GATE_IDLE = 1'b0,
        GATE_OPEN = 1'b1
    } gateState_e;

    // Lane state machines and their hold timers
    gateState_e       entryState_q, entryState_d;
    gateState_e       exitState_q,  exitState_d;
    logic [TMR_W-1:0] entryTimer_q, entryTimer_d;
    logic [TMR_W-1:0] exitTimer_q,  exitTimer_d;

    // Handshake pulses, registered so they appear the cycle after sampling
    logic entryGrant_q, entryGrant_d;
    logic entryDeny_q,  entryDeny_d;
    logic exitGrant_q,  exitGrant_d;
    logic exitDeny_q,   exitDeny_d;

    // Occupancy, capacity and statistics
    logic [CNT_W-1:0] uniParked_q, uniParked_d;
    logic [CNT_W-1:0] pubParked_q, pubParked_d;
    logic [CNT_W-1:0] pubCap_q,    pubCap_d;
    logic [15:0]      denyCount_q, denyCount_d;

    // Decision helpers, all based on the values held before the edge
    logic             entryOk;
    logic             exitOk;
    logic [4:0]       hourSat;
    logic [CW-1:0]    hourExt;
    logic [CW-1:0]    rampCap;
    logic [16:0]      denySum;

    // Public capacity for the current hour: flat before the ramp, then a
    // linear climb per hour that is clamped at the ceiling.
    always_comb begin
        hourSat = (hour > 5'd23) ? 5'd23 : hour;
        hourExt = CW'(hourSat);
        rampCap = PUB_BASE_W;
        if (hourExt >= RAMP_START_W) begin
            rampCap = PUB_BASE_W + (hourExt - RAMP_START_W) * RAMP_STEP_W;
            if (rampCap > PUB_MAX_W) begin
                rampCap = PUB_MAX_W;
            end
        end
        pubCap_d = rampCap[CNT_W-1:0];
    end

    // Whether a request sampled now would be accepted, judged against the
    // occupancy and capacity currently held in the registers.
    always_comb begin
        entryOk = 1'b0;
        exitOk  = 1'b0;
        if (entry_uni) begin
            entryOk = (uniParked_q < UNI_CAP_C);
        end else begin
            entryOk = (pubParked_q < pubCap_q);
        end
        if (exit_uni) begin
            exitOk = (uniParked_q != '0);
        end else begin
            exitOk = (pubParked_q != '0);
        end
    end

    // Entry lane: sample and decide in IDLE, then hold the barrier open.
    always_comb begin
        entryState_d = entryState_q;
        entryTimer_d = entryTimer_q;
        entryGrant_d = 1'b0;
        entryDeny_d  = 1'b0;
        unique case (entryState_q)
            GATE_IDLE: begin
                if (entry_req) begin
                    if (entryOk) begin
                        entryGrant_d = 1'b1;
                        entryState_d = GATE_OPEN;
                        entryTimer_d = HOLD_INIT;
                    end else begin
                        entryDeny_d = 1'b1;
                    end
                end
            end
            GATE_OPEN: begin
                if (entryTimer_q == '0) begin
                    entryState_d = GATE_IDLE;
                end else begin
                    entryTimer_d = entryTimer_q - TMR_W'(1);
                end
            end
            default: begin
                entryState_d = GATE_IDLE;
            end
        endcase
    end

    // Exit lane: same handshake and hold behaviour as the entry lane.
    always_comb begin
        exitState_d = exitState_q;
        exitTimer_d = exitTimer_q;
        exitGrant_d = 1'b0;
        exitDeny_d  = 1'b0;
        unique case (exitState_q)
            GATE_IDLE: begin
                if (exit_req) begin
                    if (exitOk) begin
                        exitGrant_d = 1'b1;
                        exitState_d = GATE_OPEN;
                        exitTimer_d = HOLD_INIT;
                    end else begin
                        exitDeny_d = 1'b1;
                    end
                end
            end
            GATE_OPEN: begin
                if (exitTimer_q == '0) begin
                    exitState_d = GATE_IDLE;
                end else begin
                    exitTimer_d = exitTimer_q - TMR_W'(1);
                end
            end
            default: begin
                exitState_d = GATE_IDLE;
            end
        endcase
    end

    // Occupancy follows the grants; an entry and exit of the same class in
    // one cycle cancel out. Grants already guarantee no over/underflow.
    always_comb begin
        uniParked_d = uniParked_q;
        pubParked_d = pubParked_q;
        if (entryGrant_d) begin
            if (entry_uni) begin
                uniParked_d = uniParked_d + CNT_W'(1);
            end else begin
                pubParked_d = pubParked_d + CNT_W'(1);
            end
        end
        if (exitGrant_d) begin
            if (exit_uni) begin
                uniParked_d = uniParked_d - CNT_W'(1);
            end else begin
                pubParked_d = pubParked_d - CNT_W'(1);
            end
        end
    end

    // Deny statistics: up to two denies per cycle, sticking at all-ones.
    always_comb begin
        denySum = {1'b0, denyCount_q} + {16'b0, entryDeny_d} + {16'b0, exitDeny_d};
        if (denySum > 17'h0FFFF) begin
            denyCount_d = 16'hFFFF;
        end else begin
            denyCount_d = denySum[15:0];
        end
    end

    // State register for both lanes, counters, pulses and capacity.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            entryState_q <= GATE_IDLE;
            exitState_q  <= GATE_IDLE;
            entryTimer_q <= '0;
            exitTimer_q  <= '0;
            entryGrant_q <= 1'b0;
            entryDeny_q  <= 1'b0;
            exitGrant_q  <= 1'b0;
            exitDeny_q   <= 1'b0;
            uniParked_q  <= '0;
            pubParked_q  <= '0;
            pubCap_q     <= PUB_BASE_W[CNT_W-1:0];
            denyCount_q  <= '0;
        end else begin
            entryState_q <= entryState_d;
            exitState_q  <= exitState_d;
            entryTimer_q <= entryTimer_d;
            exitTimer_q  <= exitTimer_d;
            entryGrant_q <= entryGrant_d;
            entryDeny_q  <= entryDeny_d;
            exitGrant_q  <= exitGrant_d;
            exitDeny_q   <= exitDeny_d;
            uniParked_q  <= uniParked_d;
            pubParked_q  <= pubParked_d;
            pubCap_q     <= pubCap_d;
            denyCount_q  <= denyCount_d;
        end
    end

    // Output views; free space saturates at zero when capacity has dropped
    // below the current public occupancy.
    assign entry_grant     = entryGrant_q;
    assign entry_deny      = entryDeny_q;
    assign exit_grant      = exitGrant_q;
    assign exit_deny       = exitDeny_q;
    assign entry_gate_open = (entryState_q == GATE_OPEN);
    assign exit_gate_open  = (exitState_q == GATE_OPEN);
    assign uni_parked      = uniParked_q;
    assign pub_parked      = pubParked_q;
    assign pub_cap         = pubCap_q;
    assign uni_free        = UNI_CAP_C - uniParked_q;
    assign pub_free        = (pubCap_q > pubParked_q) ? (pubCap_q - pubParked_q) : '0;
    assign uni_full        = (uni_free == '0);
    assign pub_full        = (pub_free == '0);
    assign deny_count      = denyCount_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Self-checking bench for parking_gate_controller: directed scenarios plus
// a randomized phase, all compared against a behavioural occupancy model.
module tb_parking_gate_controller;

    localparam int UNI_CAP    = 500;
    localparam int PUB_BASE   = 200;
    localparam int PUB_MAX    = 500;
    localparam int RAMP_START = 13;
    localparam int RAMP_STEP  = 50;
    localparam int CNT_W      = 10;
    localparam int GATE_HOLD  = 4;

    logic             clk;
    logic             reset_n;
    logic [4:0]       hour;
    logic             entry_req;
    logic             entry_uni;
    logic             exit_req;
    logic             exit_uni;
    logic             entry_grant;
    logic             entry_deny;
    logic             exit_grant;
    logic             exit_deny;
    logic             entry_gate_open;
    logic             exit_gate_open;
    logic [CNT_W-1:0] uni_parked;
    logic [CNT_W-1:0] pub_parked;
    logic [CNT_W-1:0] pub_cap;
    logic [CNT_W-1:0] uni_free;
    logic [CNT_W-1:0] pub_free;
    logic             uni_full;
    logic             pub_full;
    logic [15:0]      deny_count;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: plain occupancy integers and a count of how many more
    // cycles each barrier will remain open.
    int mUni, mPub, mCap, mDeny;
    int mEntryOpenLeft, mExitOpenLeft;
    int mEG, mED, mXG, mXD;

    parking_gate_controller #(
        .UNI_CAP(UNI_CAP), .PUB_BASE(PUB_BASE), .PUB_MAX(PUB_MAX),
        .RAMP_START(RAMP_START), .RAMP_STEP(RAMP_STEP),
        .CNT_W(CNT_W), .GATE_HOLD(GATE_HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hour(hour),
        .entry_req(entry_req), .entry_uni(entry_uni),
        .exit_req(exit_req), .exit_uni(exit_uni),
        .entry_grant(entry_grant), .entry_deny(entry_deny),
        .exit_grant(exit_grant), .exit_deny(exit_deny),
        .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
        .uni_parked(uni_parked), .pub_parked(pub_parked), .pub_cap(pub_cap),
        .uni_free(uni_free), .pub_free(pub_free),
        .uni_full(uni_full), .pub_full(pub_full),
        .deny_count(deny_count)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int capForHour(input int h);
        int hh;
        int c;
        hh = (h > 23) ? 23 : h;
        if (hh < RAMP_START) return PUB_BASE;
        c = PUB_BASE + (hh - RAMP_START) * RAMP_STEP;
        return (c > PUB_MAX) ? PUB_MAX : c;
    endfunction

    // Advance the model by one clock edge using the inputs held at that edge.
    task automatic modelStep();
        int preUni;
        int prePub;
        int ok;
        mEG = 0; mED = 0; mXG = 0; mXD = 0;
        if (!reset_n) begin
            mUni = 0; mPub = 0; mCap = PUB_BASE; mDeny = 0;
            mEntryOpenLeft = 0; mExitOpenLeft = 0;
            return;
        end
        preUni = mUni;
        prePub = mPub;
        if (mEntryOpenLeft > 0) begin
            mEntryOpenLeft--;
        end else if (entry_req) begin
            ok = entry_uni ? int'(preUni < UNI_CAP) : int'(prePub < mCap);
            if (ok != 0) begin
                mEG = 1;
                mEntryOpenLeft = GATE_HOLD;
                if (entry_uni) mUni++; else mPub++;
            end else begin
                mED = 1;
            end
        end
        if (mExitOpenLeft > 0) begin
            mExitOpenLeft--;
        end else if (exit_req) begin
            ok = exit_uni ? int'(preUni > 0) : int'(prePub > 0);
            if (ok != 0) begin
                mXG = 1;
                mExitOpenLeft = GATE_HOLD;
                if (exit_uni) mUni--; else mPub--;
            end else begin
                mXD = 1;
            end
        end
        mDeny = mDeny + mED + mXD;
        if (mDeny > 65535) mDeny = 65535;
        mCap = capForHour(int'(hour));
    endtask

    task automatic compareModel();
        int expPubFree;
        expPubFree = (mCap > mPub) ? (mCap - mPub) : 0;
        checkOutput("entry_grant", int'(entry_grant), mEG);
        checkOutput("entry_deny", int'(entry_deny), mED);
        checkOutput("exit_grant", int'(exit_grant), mXG);
        checkOutput("exit_deny", int'(exit_deny), mXD);
        checkOutput("entry_gate_open", int'(entry_gate_open), int'(mEntryOpenLeft > 0));
        checkOutput("exit_gate_open", int'(exit_gate_open), int'(mExitOpenLeft > 0));
        checkOutput("uni_parked", int'(uni_parked), mUni);
        checkOutput("pub_parked", int'(pub_parked), mPub);
        checkOutput("pub_cap", int'(pub_cap), mCap);
        checkOutput("uni_free", int'(uni_free), UNI_CAP - mUni);
        checkOutput("pub_free", int'(pub_free), expPubFree);
        checkOutput("uni_full", int'(uni_full), int'(mUni == UNI_CAP));
        checkOutput("pub_full", int'(pub_full), int'(expPubFree == 0));
        checkOutput("deny_count", int'(deny_count), mDeny);
    endtask

    // Run n clock cycles with the current inputs, checking after every edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            modelStep();
            #1;
            compareModel();
        end
    endtask

    task automatic setLanes(input logic eReq, input logic eUni, input logic xReq, input logic xUni);
        entry_req = eReq;
        entry_uni = eUni;
        exit_req  = xReq;
        exit_uni  = xUni;
    endtask

    int hourTable[7] = '{12, 13, 14, 15, 16, 20, 27};
    int capTable[7]  = '{200, 200, 250, 300, 350, 500, 500};

    initial begin
        int openCycles;
        int grants;
        int guard;
        int denyBefore;

        reset_n = 1'b0;
        hour    = 5'd9;
        setLanes(1'b0, 1'b0, 1'b0, 1'b0);
        mUni = 0; mPub = 0; mCap = PUB_BASE; mDeny = 0;
        mEntryOpenLeft = 0; mExitOpenLeft = 0;
        mEG = 0; mED = 0; mXG = 0; mXD = 0;

        @(negedge clk);
        applyStimulus(3);
        checkOutput("reset_pub_cap", int'(pub_cap), 200);
        checkOutput("reset_uni_free", int'(uni_free), 500);
        reset_n = 1'b1;
        applyStimulus(2);

        // Single public entry at hour 9
        setLanes(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1);
        setLanes(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("first_grant", int'(entry_grant), 1);
        checkOutput("first_pub_parked", int'(pub_parked), 1);
        checkOutput("first_pub_free", int'(pub_free), 199);
        openCycles = int'(entry_gate_open);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1);
            openCycles += int'(entry_gate_open);
        end
        checkOutput("gate_open_cycles", openCycles, 4);

        // Capacity ramp over the afternoon, and an out-of-range hour
        for (int i = 0; i < 7; i++) begin
            hour = 5'(hourTable[i]);
            applyStimulus(1);
            checkOutput("ramp_pub_cap", int'(pub_cap), capTable[i]);
        end

        // Fill the reserved pool
        setLanes(1'b1, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (mUni < UNI_CAP && guard < 4000) begin
            applyStimulus(1);
            guard++;
        end
        setLanes(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(GATE_HOLD + 1);
        checkOutput("uni_full_after_fill", int'(uni_full), 1);

        denyBefore = int'(deny_count);
        setLanes(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1);
        setLanes(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("full_uni_deny", int'(entry_deny), 1);
        checkOutput("full_uni_gate", int'(entry_gate_open), 0);
        checkOutput("full_deny_count", int'(deny_count), denyBefore + 1);

        setLanes(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1);
        setLanes(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("swap_exit_grant", int'(exit_grant), 1);
        checkOutput("swap_entry_deny", int'(entry_deny), 1);
        checkOutput("swap_uni_parked", int'(uni_parked), 499);
        applyStimulus(GATE_HOLD + 1);

        // Empty public pool: exit denied, simultaneous entry granted
        setLanes(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1);
        setLanes(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(GATE_HOLD + 1);
        setLanes(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1);
        setLanes(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("empty_exit_deny", int'(exit_deny), 1);
        checkOutput("empty_entry_grant", int'(entry_grant), 1);
        checkOutput("empty_pub_parked", int'(pub_parked), 1);
        applyStimulus(GATE_HOLD + 1);

        // Capacity drop at midnight with 450 public cars parked
        hour = 5'd23;
        applyStimulus(1);
        setLanes(1'b1, 1'b0, 1'b0, 1'b0);
        guard = 0;
        while (mPub < 450 && guard < 4000) begin
            applyStimulus(1);
            guard++;
        end
        setLanes(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(GATE_HOLD + 1);
        checkOutput("fill_pub_parked", int'(pub_parked), 450);
        hour = 5'd0;
        applyStimulus(1);
        checkOutput("wrap_pub_cap", int'(pub_cap), 200);
        checkOutput("wrap_pub_free", int'(pub_free), 0);
        checkOutput("wrap_pub_full", int'(pub_full), 1);
        setLanes(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1);
        setLanes(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_entry_deny", int'(entry_deny), 1);

        setLanes(1'b0, 1'b0, 1'b1, 1'b0);
        guard = 0;
        while (mPub > 199 && guard < 4000) begin
            applyStimulus(1);
            guard++;
        end
        setLanes(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(GATE_HOLD + 1);
        checkOutput("drain_pub_parked", int'(pub_parked), 199);
        setLanes(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1);
        setLanes(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("drain_entry_grant", int'(entry_grant), 1);
        applyStimulus(GATE_HOLD + 1);

        // Held entry request: one grant every GATE_HOLD+1 cycles
        hour = 5'd20;
        applyStimulus(1);
        setLanes(1'b1, 1'b0, 1'b0, 1'b0);
        grants = 0;
        for (int i = 0; i < 2 * (GATE_HOLD + 1) + 1; i++) begin
            applyStimulus(1);
            grants += int'(entry_grant);
        end
        checkOutput("held_grants", grants, 3);
        setLanes(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1);
        reset_n = 1'b0;
        applyStimulus(1);
        checkOutput("midreset_gate", int'(entry_gate_open), 0);
        checkOutput("midreset_pub", int'(pub_parked), 0);
        checkOutput("midreset_uni", int'(uni_parked), 0);
        reset_n = 1'b1;
        applyStimulus(1);

        // Randomized traffic with hour changes and occasional resets
        for (int i = 0; i < 4000; i++) begin
            entry_req = ($urandom_range(0, 9) < 7);
            entry_uni = 1'($urandom_range(0, 1));
            exit_req  = ($urandom_range(0, 9) < 3);
            exit_uni  = 1'($urandom_range(0, 1));
            if ((i % 60) == 0) hour = 5'($urandom_range(0, 31));
            reset_n = ($urandom_range(0, 799) != 0);
            applyStimulus(1);
        end
        reset_n = 1'b1;
        setLanes(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
